// File: rtl/uart_rx_capture_pkg.sv
// rtl/uart_rx_capture_pkg.sv - shared types and constants for the 8N1 capture receiver
package uart_rx_capture_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_HI
  } uart_rx_state_e;

  localparam int         UART_DATA_BITS = 8;
  localparam logic [7:0] UART_LF        = 8'h0A;

endpackage

// File: rtl/uart_rx_capture_if.sv
// rtl/uart_rx_capture_if.sv - ready/valid byte stream leaving the receiver
interface uart_rx_capture_if;
  import uart_rx_capture_pkg::*;

  logic [UART_DATA_BITS-1:0] data_o;
  logic                      valid_o;
  logic                      ready_i;

  modport master (output data_o, output valid_o, input ready_i);
  modport slave  (input data_o, input valid_o, output ready_i);

endinterface

// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - synchronous byte FIFO with a registered head word
module uart_rx_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] rdata
);

  localparam int AW = $clog2(DEPTH);
  localparam int UW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr, rd_next;
  logic [UW-1:0]    used;
  logic             push_ok, pop_ok;

  assign empty   = (used == '0);
  assign full    = (used == UW'(DEPTH));
  assign pop_ok  = pop && !empty;
  // A full FIFO still accepts a write when the head leaves in the same cycle.
  assign push_ok = push && (!full || pop_ok);
  assign rd_next = rd_ptr + AW'(1);

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      used   <= '0;
      rdata  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_next;
      used <= used + UW'(push_ok) - UW'(pop_ok);
      // The head register tracks whichever entry sits at rd_ptr next cycle.
      if (pop_ok) begin
        if (used == UW'(1)) begin
          if (push_ok) rdata <= wdata;
        end else begin
          rdata <= mem[rd_next];
        end
      end else if (empty && push_ok) begin
        rdata <= wdata;
      end
    end
  end

endmodule

// File: rtl/uart_rx_capture.sv
// rtl/uart_rx_capture.sv - 8N1 receiver: synchronizer, bit timing FSM, flags and byte FIFO
module uart_rx_capture
  import uart_rx_capture_pkg::*;
#(
  parameter int CLK_DIV    = 32,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     rx_i,
  input  logic                     en_i,
  input  logic                     clr_i,
  uart_rx_capture_if.master        byte_if,
  output logic                     frame_err_o,
  output logic                     overflow_o,
  output logic [15:0]              count_o,
  output logic                     line_o
);

  localparam int            CW        = $clog2(CLK_DIV);
  localparam logic [CW-1:0] HALF_LOAD = CW'(CLK_DIV / 2 - 1);
  localparam logic [CW-1:0] FULL_LOAD = CW'(CLK_DIV - 1);

  logic                      rx_meta, rx_s, rx_prev;
  logic [1:0]                settle;
  logic                      armed;
  uart_rx_state_e            state;
  logic [CW-1:0]             bit_cnt;
  logic [2:0]                bit_idx;
  logic [UART_DATA_BITS-1:0] shreg;
  logic                      fall, tick, push_byte, stop_bad;
  logic                      pop_fire, accept, fifo_full, fifo_empty;

  assign fall      = armed && rx_prev && !rx_s;
  assign tick      = (bit_cnt == '0);
  assign push_byte = (state == STOP) && tick && rx_s;
  assign stop_bad  = (state == STOP) && tick && !rx_s;
  assign pop_fire  = byte_if.ready_i && !fifo_empty;
  assign accept    = push_byte && (!fifo_full || pop_fire);
  assign byte_if.valid_o = !fifo_empty;

  // Edges are only trusted once the synchronizer holds real samples and the
  // line has been seen high, so a line held low across reset is not a start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
      rx_prev <= 1'b1;
      settle  <= 2'd0;
      armed   <= 1'b0;
    end else begin
      rx_meta <= rx_i;
      rx_s    <= rx_meta;
      rx_prev <= rx_s;
      if (!settle[1]) settle <= settle + 2'd1;
      if (settle[1] && rx_s) armed <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      bit_cnt <= '0;
      bit_idx <= '0;
      shreg   <= '0;
    end else begin
      if (!tick) bit_cnt <= bit_cnt - CW'(1);
      case (state)
        IDLE: begin
          if (fall && en_i) begin
            state   <= START;
            bit_cnt <= HALF_LOAD;
          end
        end
        START: begin
          if (tick) begin
            if (!rx_s) begin
              state   <= DATA;
              bit_cnt <= FULL_LOAD;
              bit_idx <= '0;
            end else begin
              state <= IDLE;
            end
          end
        end
        DATA: begin
          if (tick) begin
            shreg   <= {rx_s, shreg[UART_DATA_BITS-1:1]};
            bit_cnt <= FULL_LOAD;
            bit_idx <= bit_idx + 3'd1;
            if (bit_idx == 3'(UART_DATA_BITS - 1)) state <= STOP;
          end
        end
        STOP: begin
          if (tick) state <= rx_s ? IDLE : WAIT_HI;
        end
        WAIT_HI: begin
          if (rx_s) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_err_o <= 1'b0;
      overflow_o  <= 1'b0;
      count_o     <= 16'd0;
      line_o      <= 1'b0;
    end else begin
      line_o <= accept && (shreg == UART_LF);
      if (clr_i) begin
        frame_err_o <= 1'b0;
        overflow_o  <= 1'b0;
        count_o     <= 16'd0;
      end else begin
        if (stop_bad)                          frame_err_o <= 1'b1;
        if (push_byte && !accept)              overflow_o  <= 1'b1;
        if (accept && (count_o != 16'hFFFF))   count_o     <= count_o + 16'd1;
      end
    end
  end

  uart_rx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (UART_DATA_BITS)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push_byte),
    .pop   (byte_if.ready_i),
    .wdata (shreg),
    .full  (fifo_full),
    .empty (fifo_empty),
    .rdata (byte_if.data_o)
  );

endmodule

// File: tb/tb_uart_rx_capture.sv
// tb/tb_uart_rx_capture.sv - scoreboard bench for the 8N1 capture receiver
module tb_uart_rx_capture;

  localparam int CLK_DIV = 32;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rx_i;
  logic        en_i;
  logic        clr_i;
  logic        frame_err_o;
  logic        overflow_o;
  logic [15:0] count_o;
  logic        line_o;

  uart_rx_capture_if bus ();

  uart_rx_capture #(
    .CLK_DIV    (CLK_DIV),
    .FIFO_DEPTH (16)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .rx_i        (rx_i),
    .en_i        (en_i),
    .clr_i       (clr_i),
    .byte_if     (bus),
    .frame_err_o (frame_err_o),
    .overflow_o  (overflow_o),
    .count_o     (count_o),
    .line_o      (line_o)
  );

  always #5 clk = ~clk;

  int         vectors = 0;
  int         errors  = 0;
  int         line_pulses = 0;
  logic [7:0] exp_q[$];
  logic [7:0] exp_b;

  task automatic check(input string name, input int act, input int req);
    vectors++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: actual %0h required %0h", name, act, req);
    end
  endtask

  task automatic tick_n(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop, input bit expect_push);
    if (expect_push) exp_q.push_back(b);
    rx_i = 1'b0;
    tick_n(CLK_DIV);
    for (int i = 0; i < 8; i++) begin
      rx_i = b[i];
      tick_n(CLK_DIV);
    end
    rx_i = stop;
    tick_n(CLK_DIV);
    rx_i = 1'b1;
  endtask

  task automatic pulse_clr();
    clr_i = 1'b1;
    tick_n(1);
    clr_i = 1'b0;
  endtask

  // Monitor: every byte the consumer takes is matched against the scoreboard.
  always @(negedge clk) begin
    if (rst_n) begin
      if (line_o) line_pulses++;
      if (bus.valid_o && bus.ready_i) begin
        vectors++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL pop_unexpected: actual %02h required no byte", bus.data_o);
        end else begin
          exp_b = exp_q.pop_front();
          if (bus.data_o !== exp_b) begin
            errors++;
            $display("FAIL pop_data: actual %02h required %02h", bus.data_o, exp_b);
          end
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    rx_i  = 1'b1;
    en_i  = 1'b1;
    clr_i = 1'b0;
    bus.ready_i = 1'b1;
    tick_n(3);
    check("rst_data",      int'(bus.data_o),  0);
    check("rst_valid",     int'(bus.valid_o), 0);
    check("rst_frame_err", int'(frame_err_o), 0);
    check("rst_overflow",  int'(overflow_o),  0);
    check("rst_count",     int'(count_o),     0);
    check("rst_line",      int'(line_o),      0);
    rst_n = 1'b1;
    tick_n(10);

    // Single byte with latency measured from the rx_i falling edge.
    fork
      send_byte(8'h65, 1'b1, 1'b1);
      begin : meas
        int n;
        n = 0;
        while (n < 400) begin
          @(posedge clk);
          n++;
          @(negedge clk);
          if (bus.valid_o) break;
        end
        check("latency", n, 307);
      end
    join
    tick_n(5);
    check("single_count", int'(count_o), 1);
    check("single_line",  line_pulses,   0);

    // "OK\n" back-to-back.
    pulse_clr();
    send_byte(8'h4F, 1'b1, 1'b1);
    send_byte(8'h4B, 1'b1, 1'b1);
    send_byte(8'h0A, 1'b1, 1'b1);
    tick_n(5);
    check("ok_count", int'(count_o), 3);
    check("ok_line",  line_pulses,   1);

    // 10-cycle glitch: no push, no flag.
    rx_i = 1'b0;
    tick_n(10);
    rx_i = 1'b1;
    tick_n(400);
    check("glitch_count",     int'(count_o),     3);
    check("glitch_valid",     int'(bus.valid_o), 0);
    check("glitch_frame_err", int'(frame_err_o), 0);
    check("glitch_overflow",  int'(overflow_o),  0);

    // Framing error followed by a held-low break, then a good byte.
    send_byte(8'hA5, 1'b0, 1'b0);
    rx_i = 1'b0;
    tick_n(100);
    check("ferr_set",   int'(frame_err_o), 1);
    check("ferr_count", int'(count_o),     3);
    rx_i = 1'b1;
    tick_n(20);
    send_byte(8'h31, 1'b1, 1'b1);
    tick_n(5);
    check("ferr_next_count", int'(count_o),     4);
    check("ferr_still_set",  int'(frame_err_o), 1);
    pulse_clr();
    check("ferr_cleared",  int'(frame_err_o), 0);
    check("clr_count",     int'(count_o),     0);

    // Overflow: 17 bytes into a 16-deep FIFO with the consumer stalled.
    bus.ready_i = 1'b0;
    for (int i = 0; i <= 16; i++) send_byte(8'(i), 1'b1, i < 16);
    tick_n(5);
    check("ovf_flag",  int'(overflow_o),  1);
    check("ovf_count", int'(count_o),     16);
    check("ovf_line",  line_pulses,       2);
    check("ovf_head",  int'(bus.data_o),  0);
    bus.ready_i = 1'b1;
    tick_n(30);
    check("ovf_drained", exp_q.size(),     0);
    check("ovf_valid",   int'(bus.valid_o), 0);

    // Reset during data bit 3 with the line held low across reset.
    pulse_clr();
    bus.ready_i = 1'b0;
    send_byte(8'h77, 1'b1, 1'b0);
    tick_n(5);
    check("pre_rst_valid", int'(bus.valid_o), 1);
    check("pre_rst_count", int'(count_o),     1);
    rx_i = 1'b0;
    tick_n(CLK_DIV);
    for (int i = 0; i < 3; i++) begin
      rx_i = (8'hC3 >> i) & 8'h01;
      tick_n(CLK_DIV);
    end
    rx_i = 1'b0;
    tick_n(CLK_DIV / 2);
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", int'(bus.valid_o), 0);
    check("mid_rst_count", int'(count_o),     0);
    check("mid_rst_data",  int'(bus.data_o),  0);
    tick_n(3);
    rst_n = 1'b1;
    bus.ready_i = 1'b1;
    tick_n(50);
    rx_i = 1'b1;
    tick_n(40);
    check("low_line_no_start", int'(frame_err_o), 0);
    send_byte(8'h5A, 1'b1, 1'b1);
    tick_n(5);
    check("post_rst_count",     int'(count_o),     1);
    check("post_rst_frame_err", int'(frame_err_o), 0);
    tick_n(5);
    check("final_queue", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
